wb_port_arbiter: RTL and testbench

- Shares the single register-file write port between the main pipeline write-back (WB) and the out-of-order multiplier result stream from the pipelined multiplier manager.
- Main-pipeline writes always win. A colliding multiplier result is parked in a small in-order FIFO and written on the next free cycle.
- The block raises a stall request so the multiplier never overflows the FIFO.
- It raises a hazard stall so ID never reads, or re-targets, a register whose multiplier result is still pending.

---
 rtl/wb_port_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Shares the single register-file write port between the main pipeline
// write-back and the out-of-order multiplier result stream. Pipeline writes
// always win. A colliding multiplier result is parked in an in-order FIFO and
// retired on the next free cycle.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   pipe_we/addr/data  WB-stage write request
//   mult_we/addr/data  multiplier result
//   rs1_*, rs2_*       ID source reads (hazard check)
//   rd_we_id/addr_id   ID destination (hazard check)
//   rf_we/waddr/wdata  registered register-file write port
//   mult_stall_req     registered multiply-issue block (FIFO headroom)
//   hz_stall_req       combinational ID stall on a pending-result conflict
//   fifo_cnt           number of parked entries
//   ovf_err            sticky FIFO overflow flag
module wb_port_arbiter #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int FIFO_DEPTH  = 4,
  parameter int MULT_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pipe_we,
  input  logic [ADDR_W-1:0]             pipe_addr,
  input  logic [DATA_W-1:0]             pipe_data,
  input  logic                          mult_we,
  input  logic [ADDR_W-1:0]             mult_addr,
  input  logic [DATA_W-1:0]             mult_data,
  input  logic                          rs1_re,
  input  logic [ADDR_W-1:0]             rs1_addr,
  input  logic                          rs2_re,
  input  logic [ADDR_W-1:0]             rs2_addr,
  input  logic                          rd_we_id,
  input  logic [ADDR_W-1:0]             rd_addr_id,
  output logic                          rf_we,
  output logic [ADDR_W-1:0]             rf_waddr,
  output logic [DATA_W-1:0]             rf_wdata,
  output logic                          mult_stall_req,
  output logic                          hz_stall_req,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
  output logic                          ovf_err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TH_INT = (FIFO_DEPTH > MULT_STAGES) ? (FIFO_DEPTH - MULT_STAGES) : 0;
  localparam logic [CW-1:0] STALL_TH = CW'(TH_INT);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  // FIFO storage; a slot's valid bit is only set while it is occupied and
  // not killed by a younger pipeline write to the same register.
  logic [ADDR_W-1:0]     fifo_addr_q [FIFO_DEPTH];
  logic [DATA_W-1:0]     fifo_data_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic                  rf_we_q, rf_we_d;
  logic [ADDR_W-1:0]     rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0]     rf_wdata_q, rf_wdata_d;
  logic                  mstall_q;
  logic                  ovf_q, ovf_d;

  logic pipe_v, mult_v, fifo_empty;
  logic push, pop, push_ok;

  assign pipe_v     = pipe_we && (pipe_addr != '0);
  assign mult_v     = mult_we && (mult_addr != '0);
  assign fifo_empty = (cnt_q == '0);
  // A push into a full FIFO only lands if the same edge frees the head slot.
  assign push_ok    = push && (pop || (cnt_q != FULL_CNT));

  always_comb begin
    push       = 1'b0;
    pop        = 1'b0;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (pipe_v) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = pipe_addr;
      rf_wdata_d = pipe_data;
      push       = mult_v;
    end else if (!fifo_empty) begin
      // A killed head still consumes this slot but writes nothing.
      pop = 1'b1;
      if (vld_q[rd_ptr_q]) begin
        rf_we_d    = 1'b1;
        rf_waddr_d = fifo_addr_q[rd_ptr_q];
        rf_wdata_d = fifo_data_q[rd_ptr_q];
      end
      push = mult_v;
    end else if (mult_v) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = mult_addr;
      rf_wdata_d = mult_data;
    end
  end

  always_comb begin
    vld_d = vld_q;
    if (pipe_v) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        if (vld_q[i] && (fifo_addr_q[i] == pipe_addr)) begin
          vld_d[i] = 1'b0;
        end
      end
    end
    if (pop) begin
      vld_d[rd_ptr_q] = 1'b0;
    end
    // Applied last so a same-cycle matching push stays valid.
    if (push_ok) begin
      vld_d[wr_ptr_q] = 1'b1;
    end
  end

  assign cnt_d = cnt_q + CW'(push_ok) - CW'(pop);
  assign ovf_d = ovf_q | (push & ~push_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      mstall_q   <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      vld_q      <= vld_d;
      cnt_q      <= cnt_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      mstall_q   <= (cnt_d >= STALL_TH);
      ovf_q      <= ovf_d;
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      fifo_addr_q[wr_ptr_q] <= mult_addr;
      fifo_data_q[wr_ptr_q] <= mult_data;
    end
  end

  // Hazard: any enabled, nonzero ID register that matches a pending write.
  logic [2:0]        chk_en;
  logic [ADDR_W-1:0] chk_addr [3];

  always_comb begin
    chk_en      = {rd_we_id, rs2_re, rs1_re};
    chk_addr[0] = rs1_addr;
    chk_addr[1] = rs2_addr;
    chk_addr[2] = rd_addr_id;
    hz_stall_req = 1'b0;
    for (int unsigned k = 0; k < 3; k++) begin
      if (chk_en[k] && (chk_addr[k] != '0)) begin
        if (mult_we && (mult_addr == chk_addr[k])) begin
          hz_stall_req = 1'b1;
        end
        if (rf_we_q && (rf_waddr_q == chk_addr[k])) begin
          hz_stall_req = 1'b1;
        end
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
          if (vld_q[i] && (fifo_addr_q[i] == chk_addr[k])) begin
            hz_stall_req = 1'b1;
          end
        end
      end
    end
  end

  assign rf_we          = rf_we_q;
  assign rf_waddr       = rf_waddr_q;
  assign rf_wdata       = rf_wdata_q;
  assign mult_stall_req = mstall_q;
  assign fifo_cnt       = cnt_q;
  assign ovf_err        = ovf_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              pipe_we, mult_we, rs1_re, rs2_re, rd_we_id;
  logic [ADDR_W-1:0] pipe_addr, mult_addr, rs1_addr, rs2_addr, rd_addr_id;
  logic [DATA_W-1:0] pipe_data, mult_data;
  logic              rf_we, mult_stall_req, hz_stall_req, ovf_err;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [2:0]        fifo_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_port_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(4), .MULT_STAGES(2)
  ) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_data(pipe_data),
    .mult_we(mult_we), .mult_addr(mult_addr), .mult_data(mult_data),
    .rs1_re(rs1_re), .rs1_addr(rs1_addr), .rs2_re(rs2_re), .rs2_addr(rs2_addr),
    .rd_we_id(rd_we_id), .rd_addr_id(rd_addr_id),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .mult_stall_req(mult_stall_req), .hz_stall_req(hz_stall_req),
    .fifo_cnt(fifo_cnt), .ovf_err(ovf_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pipe_we = 0; pipe_addr = '0; pipe_data = '0;
    mult_we = 0; mult_addr = '0; mult_data = '0;
    rs1_re = 0; rs1_addr = '0; rs2_re = 0; rs2_addr = '0;
    rd_we_id = 0; rd_addr_id = '0;
  endtask

  task automatic set_pipe(input logic en, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    pipe_we = en; pipe_addr = a; pipe_data = d;
  endtask

  task automatic set_mult(input logic en, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    mult_we = en; mult_addr = a; mult_data = d;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    tick(); tick();
    rst = 0;
    check("rst_rf_we", rf_we, 0);
    check("rst_waddr", rf_waddr, 0);
    check("rst_wdata", rf_wdata, 0);
    check("rst_cnt", fifo_cnt, 0);
    check("rst_mstall", mult_stall_req, 0);
    check("rst_ovf", ovf_err, 0);
    tick();
    check("idle_rf_we", rf_we, 0);

    // pipe alone
    set_pipe(1, 5'd5, 32'h11); tick(); idle_inputs();
    check("pipe_we", rf_we, 1);
    check("pipe_addr", rf_waddr, 5);
    check("pipe_data", rf_wdata, 32'h11);

    // mult alone goes direct
    set_mult(1, 5'd6, 32'h22); tick(); idle_inputs();
    check("mult_we", rf_we, 1);
    check("mult_addr", rf_waddr, 6);
    check("mult_data", rf_wdata, 32'h22);
    check("mult_cnt", fifo_cnt, 0);

    // collision
    set_pipe(1, 5'd5, 32'h11); set_mult(1, 5'd7, 32'h33); tick(); idle_inputs();
    check("col1_addr", rf_waddr, 5);
    check("col1_cnt", fifo_cnt, 1);
    check("col1_mstall", mult_stall_req, 0);
    tick();
    check("col2_we", rf_we, 1);
    check("col2_addr", rf_waddr, 7);
    check("col2_data", rf_wdata, 32'h33);
    check("col2_cnt", fifo_cnt, 0);
    tick();
    check("col3_we", rf_we, 0);
    check("col3_hold_addr", rf_waddr, 7);
    check("col3_hold_data", rf_wdata, 32'h33);

    // backpressure and overflow
    set_pipe(1, 5'd10, 32'hA0);
    for (int k = 1; k <= 4; k++) begin
      set_mult(1, ADDR_W'(k), 32'h100 + DATA_W'(k));
      tick();
      check("bp_cnt", fifo_cnt, 64'(k));
      check("bp_mstall", mult_stall_req, (k >= 2) ? 64'd1 : 64'd0);
      check("bp_ovf", ovf_err, 0);
      check("bp_pipe_addr", rf_waddr, 10);
    end
    set_mult(1, 5'd8, 32'h108); tick();
    check("ovf_cnt", fifo_cnt, 4);
    check("ovf_flag", ovf_err, 1);
    idle_inputs();
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("pop_we", rf_we, 1);
      check("pop_addr", rf_waddr, 64'(k));
      check("pop_data", rf_wdata, 64'h100 + 64'(k));
      check("pop_cnt", fifo_cnt, 64'(4 - k));
      check("pop_mstall", mult_stall_req, (4 - k >= 2) ? 64'd1 : 64'd0);
    end
    tick();
    check("drain_we", rf_we, 0);
    check("ovf_sticky", ovf_err, 1);
    rst = 1; tick(); rst = 0;
    check("ovf_cleared", ovf_err, 0);
    check("rst2_cnt", fifo_cnt, 0);

    // park x9, hazard checks
    set_pipe(1, 5'd5, 32'h11); set_mult(1, 5'd9, 32'h44); tick();
    set_pipe(0, '0, '0); set_mult(0, '0, '0);
    check("park_cnt", fifo_cnt, 1);
    rs1_re = 1; rs1_addr = 5'd9; #1;
    check("hz_rs1_x9", hz_stall_req, 1);
    rs1_addr = 5'd0; #1;
    check("hz_rs1_x0", hz_stall_req, 0);
    rs1_addr = 5'd3; #1;
    check("hz_rs1_x3", hz_stall_req, 0);
    rs1_re = 0; rd_we_id = 1; rd_addr_id = 5'd9; #1;
    check("hz_rd_x9", hz_stall_req, 1);
    rd_we_id = 0; rd_addr_id = '0;
    rs2_re = 1; rs2_addr = 5'd12; set_mult(1, 5'd12, 32'h0); #1;
    check("hz_mult_inflight", hz_stall_req, 1);
    set_mult(0, '0, '0); rs2_addr = 5'd5; #1;
    check("hz_rf_pending", hz_stall_req, 1);
    rs2_re = 0; rs2_addr = '0;

    // WAW kill: younger pipe write to x9
    set_pipe(1, 5'd9, 32'h55); tick(); idle_inputs();
    check("waw_we", rf_we, 1);
    check("waw_addr", rf_waddr, 9);
    check("waw_data", rf_wdata, 32'h55);
    check("waw_cnt", fifo_cnt, 1);
    rs1_re = 1; rs1_addr = 5'd9; rf_pending_wait();
    tick();
    check("kill_pop_we", rf_we, 0);
    check("kill_pop_cnt", fifo_cnt, 0);
    check("kill_no_44", rf_wdata, 32'h55);
    check("hz_after_kill", hz_stall_req, 0);
    rs1_re = 0; rs1_addr = '0;

    // x0 never written or parked
    set_mult(1, 5'd0, 32'h77); tick();
    check("x0_mult_we", rf_we, 0);
    check("x0_mult_cnt", fifo_cnt, 0);
    set_pipe(1, 5'd5, 32'h66); tick(); idle_inputs();
    check("x0_park_cnt", fifo_cnt, 0);
    check("x0_pipe_addr", rf_waddr, 5);
    set_pipe(1, 5'd0, 32'h99); tick(); idle_inputs();
    check("x0_pipe_we", rf_we, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Killed slot is still occupied but no longer a pending x9 write; only the
  // in-flight rf write of x9 (0x55) keeps the hazard up this cycle.
  task automatic rf_pending_wait();
    #1;
    check("hz_rf_x9_pending", hz_stall_req, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
